// File: rtl/kf_param_loader.sv
// Write-side sequencer for the Kalman filter memory registers: turns a load command
// plus a valid/ready word stream into registered data-bank, Q and R write strobes.
module kf_param_loader #(
    parameter int W     = 24,
    parameter int DEPTH = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW-1:0] base_addr,
    input  logic [ADDRW:0]   count,
    input  logic             load_qr,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic             db_we,
    output logic [ADDRW-1:0] db_waddr,
    output logic [W-1:0]     db_wdata,
    output logic             rq_we,
    output logic [W-1:0]     rq_d,
    output logic             rd_we,
    output logic [W-1:0]     rd_d
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DB   = 3'd1;
    localparam logic [2:0] ST_Q    = 3'd2;
    localparam logic [2:0] ST_R    = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    localparam logic [ADDRW+1:0] DEPTH_X = (ADDRW+2)'(DEPTH);

    logic [2:0]       state;
    logic [ADDRW-1:0] addr;
    logic [ADDRW:0]   rem;
    logic             qr_flag;
    logic             err_flag;
    logic             hs;
    logic             cmd_err;
    logic [ADDRW+1:0] end_addr;

    // Range check is done two bits wider than the address so base+count cannot wrap.
    assign end_addr = {2'b00, base_addr} + {1'b0, count};
    assign cmd_err  = ((count == '0) && !load_qr)
                    || ({1'b0, count} > DEPTH_X)
                    || (end_addr > DEPTH_X);

    assign s_ready = (state == ST_DB) || (state == ST_Q) || (state == ST_R);
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_FIN);
    assign err     = (state == ST_FIN) && err_flag;
    assign hs      = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            rem      <= '0;
            qr_flag  <= 1'b0;
            err_flag <= 1'b0;
            db_we    <= 1'b0;
            db_waddr <= '0;
            db_wdata <= '0;
            rq_we    <= 1'b0;
            rq_d     <= '0;
            rd_we    <= 1'b0;
            rd_d     <= '0;
        end else begin
            db_we <= 1'b0;
            rq_we <= 1'b0;
            rd_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        qr_flag <= load_qr;
                        addr    <= base_addr;
                        rem     <= count;
                        if (cmd_err) begin
                            err_flag <= 1'b1;
                            state    <= ST_FIN;
                        end else if (count != '0) begin
                            state <= ST_DB;
                        end else begin
                            state <= ST_Q;
                        end
                    end
                end
                ST_DB: begin
                    if (hs) begin
                        db_we    <= 1'b1;
                        db_waddr <= addr;
                        db_wdata <= s_data;
                        addr     <= addr + ADDRW'(1);
                        rem      <= rem - (ADDRW+1)'(1);
                        if (rem == (ADDRW+1)'(1)) begin
                            state <= qr_flag ? ST_Q : ST_FIN;
                        end
                    end
                end
                ST_Q: begin
                    if (hs) begin
                        rq_we <= 1'b1;
                        rq_d  <= s_data;
                        state <= ST_R;
                    end
                end
                ST_R: begin
                    if (hs) begin
                        rd_we <= 1'b1;
                        rd_d  <= s_data;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    err_flag <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kf_param_loader.sv
// Scoreboard bench for kf_param_loader: stimulus queues expected strobes/done pulses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_kf_param_loader;

    localparam int W     = 24;
    localparam int DEPTH = 32;
    localparam int ADDRW = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [ADDRW-1:0] base_addr = '0;
    logic [ADDRW:0]   count = '0;
    logic             load_qr = 1'b0;
    logic             s_valid = 1'b0;
    logic [W-1:0]     s_data = '0;
    logic             busy, done, err, s_ready;
    logic             db_we, rq_we, rd_we;
    logic [ADDRW-1:0] db_waddr;
    logic [W-1:0]     db_wdata, rq_d, rd_d;

    kf_param_loader #(.W(W), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .load_qr(load_qr), .busy(busy), .done(done), .err(err), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .db_we(db_we), .db_waddr(db_waddr),
        .db_wdata(db_wdata), .rq_we(rq_we), .rq_d(rq_d), .rd_we(rd_we), .rd_d(rd_d)
    );

    always #5 clk = ~clk;

    // kind: 0 = data bank write, 1 = Q write, 2 = R write, 3 = done pulse (data = err)
    typedef struct {
        int           kind;
        int           addr;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           fails = 0;
    int           n_db = 0;
    int           n_strobe = 0;
    int           n_hs = 0;
    logic [W-1:0] bank [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input int addr, input logic [W-1:0] d);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int addr, input logic [W-1:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_event: kind %0d data 0x%0h with nothing expected at %0t",
                     kind, d, $time);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == 0) chk("db_waddr", addr, e.addr);
            chk("event_data", d, e.data);
        end
    endtask

    always @(posedge clk) begin
        if (db_we) bank[db_waddr] <= db_wdata;
    end

    always @(negedge clk) begin
        if (db_we || rq_we || rd_we) begin
            chk("strobe_onehot", 32'(db_we) + 32'(rq_we) + 32'(rd_we), 1);
        end
        if (db_we) begin
            n_db++;
            n_strobe++;
            pop_cmp(0, int'(db_waddr), db_wdata);
        end
        if (rq_we) begin
            n_strobe++;
            pop_cmp(1, 0, rq_d);
        end
        if (rd_we) begin
            n_strobe++;
            pop_cmp(2, 0, rd_d);
        end
        if (done) pop_cmp(3, 0, {{(W-1){1'b0}}, err});
        else if (err) chk("err_without_done", err, 0);
    end

    // All tasks start and end just after a falling edge.
    task automatic issue(input int b, input int c, input bit qr);
        base_addr = ADDRW'(b);
        count     = (ADDRW+1)'(c);
        load_qr   = qr;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: s_ready low for %0d cycles, expected high", n);
        end else begin
            n_hs++;
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        logic [31:0] agg;
        agg = {28'd0, busy, done, err, s_ready};
        chk({tag, "_ctrl"}, agg, 0);
        chk({tag, "_db_we"}, db_we, 0);
        chk({tag, "_db_waddr"}, db_waddr, 0);
        chk({tag, "_db_wdata"}, db_wdata, 0);
        chk({tag, "_rq"}, {7'd0, rq_we, rq_d}, 0);
        chk({tag, "_rd"}, {7'd0, rd_we, rd_d}, 0);
    endtask

    initial begin
        int s0, h0, d0, n;

        // Reset
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Four data words at 3..6, no Q/R
        for (int i = 0; i < 4; i++) expect_ev(0, 3 + i, 24'h000011 + W'(i));
        expect_ev(3, 0, 0);
        issue(3, 4, 1'b0);
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 4; i++) send(24'h000011 + W'(i));
        s_valid = 1'b0;
        chk("done_with_last_write", {30'd0, done, db_we}, 3);
        @(negedge clk);
        chk("busy_cleared_t1", busy, 0);
        for (int i = 0; i < 4; i++) chk("bank_readback", bank[3 + i], 24'h000011 + W'(i));

        // Q/R only
        expect_ev(1, 0, 24'h7FFFFF);
        expect_ev(2, 0, 24'h800000);
        expect_ev(3, 0, 0);
        issue(0, 0, 1'b1);
        send(24'h7FFFFF);
        send(24'h800000);
        s_valid = 1'b0;
        @(negedge clk);
        chk("busy_cleared_t2", busy, 0);

        // Full bank plus Q/R with a valid gap every third word
        for (int i = 0; i < 32; i++) expect_ev(0, i, 24'h100000 + W'(i));
        expect_ev(1, 0, 24'h100020);
        expect_ev(2, 0, 24'h100021);
        expect_ev(3, 0, 0);
        s0 = n_strobe;
        h0 = n_hs;
        issue(0, 32, 1'b1);
        for (int i = 0; i < 34; i++) begin
            if (i % 3 == 2) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            send(24'h100000 + W'(i));
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("full_strobe_count", n_strobe - s0, 34);
        chk("full_handshake_count", n_hs - h0, 34);

        // Rejected commands
        for (int k = 0; k < 3; k++) begin
            expect_ev(3, 0, 1);
            case (k)
                0: issue(30, 3, 1'b0);
                1: issue(0, 33, 1'b0);
                default: issue(0, 0, 1'b0);
            endcase
            chk("err_pulse", {30'd0, done, err}, 3);
            chk("err_no_ready", s_ready, 0);
            @(negedge clk);
            chk("err_busy_cleared", busy, 0);
        end

        // start ignored during DB and FIN, accepted right after FIN
        expect_ev(0, 10, 24'hAA0001);
        expect_ev(0, 11, 24'hAA0002);
        expect_ev(3, 0, 0);
        expect_ev(0, 20, 24'hBB0001);
        expect_ev(3, 0, 0);
        issue(10, 2, 1'b0);
        send(24'hAA0001);
        s_valid = 1'b0;
        issue(0, 5, 1'b1);
        chk("busy_during_db", busy, 1);
        send(24'hAA0002);
        s_valid   = 1'b0;
        chk("done_in_fin", done, 1);
        base_addr = 0;
        count     = 3;
        load_qr   = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        chk("idle_after_fin", busy, 0);
        issue(20, 1, 1'b0);
        chk("restart_accepted", busy, 1);
        send(24'hBB0001);
        s_valid = 1'b0;
        @(negedge clk);
        chk("busy_cleared_t5", busy, 0);

        // Reset after the 2nd of 5 handshakes
        d0 = n_db;
        expect_ev(0, 8, 24'hCC0001);
        expect_ev(0, 9, 24'hCC0002);
        issue(8, 5, 1'b0);
        send(24'hCC0001);
        send(24'hCC0002);
        s_data = 24'hCC0003;
        rst    = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        check_zero("abort");
        chk("abort_db_writes", n_db - d0, 2);
        expect_ev(0, 0, 24'hDD0001);
        expect_ev(3, 0, 0);
        issue(0, 1, 1'b0);
        send(24'hDD0001);
        s_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_done", busy, 0);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
